// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: ID-stage hazard unit.
// Tracks pending destinations of long-latency producers (load/mul/div) and the
// number of long ops in flight, produces the ID stall and the operand forwarding
// selects for the EXE ALU, MEM ALU and long-op writeback bus.
// Optional feature: define SB_PERF_EN to add the stall_cycles performance counter
// and its perf_clr synchronous clear.
//
// Long ops whose destination is r0 are counted in out_cnt but never mark a
// pending bit; their completion arrives with wb_rn==0 and only decrements the
// counter, without any pending-bit check.
module pipe_scoreboard #(
    parameter int NREG   = 32,
    parameter int RNW    = 5,
    parameter int MAXOUT = 4,
    parameter int CW     = $clog2(MAXOUT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RNW-1:0]  id_rs,
    input  logic [RNW-1:0]  id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [RNW-1:0]  id_rd,
    input  logic            id_wreg,
    input  logic            id_long,
    input  logic            e_wreg,
    input  logic [RNW-1:0]  e_rn,
    input  logic            m_wreg,
    input  logic [RNW-1:0]  m_rn,
    input  logic            wb_done,
    input  logic [RNW-1:0]  wb_rn,
    output logic            nostall,
    output logic [1:0]      fwda,
    output logic [1:0]      fwdb,
    output logic [NREG-1:0] pending,
    output logic [CW-1:0]   out_cnt,
`ifdef SB_PERF_EN
    input  logic            perf_clr,
    output logic [31:0]     stall_cycles,
`endif
    output logic            sb_err
);

    localparam logic [CW-1:0] MAXOUT_C = CW'(MAXOUT);

    logic [NREG-1:0] pending_q, pending_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic            sb_err_q,  sb_err_d;

    logic raw_rs, raw_rt, waw, full;
    logic acc, long_acc, set_en, clr_en;

    // Forwarding priority: youngest producer (EXE) first, then MEM, then the
    // long-op writeback bus; r0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [RNW-1:0] rn,
        input logic           e_w,
        input logic [RNW-1:0] e_n,
        input logic           m_w,
        input logic [RNW-1:0] m_n,
        input logic           wb_w,
        input logic [RNW-1:0] wb_n
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rn != '0) begin
            if (e_w && (e_n == rn)) begin
                sel = 2'b01;
            end else if (m_w && (m_n == rn)) begin
                sel = 2'b10;
            end else if (wb_w && (wb_n == rn)) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    // Hazard detection and stall; a same-cycle writeback of the register
    // resolves the hazard because it is forwarded from the writeback bus.
    always_comb begin
        raw_rs  = id_use_rs & (id_rs != '0) & pending_q[id_rs]
                  & ~(wb_done & (wb_rn == id_rs));
        raw_rt  = id_use_rt & (id_rt != '0) & pending_q[id_rt]
                  & ~(wb_done & (wb_rn == id_rt));
        waw     = id_wreg & (id_rd != '0) & pending_q[id_rd]
                  & ~(wb_done & (wb_rn == id_rd));
        full    = id_long & id_wreg & (out_cnt_q == MAXOUT_C) & ~wb_done;
        nostall = ~(id_valid & (raw_rs | raw_rt | waw | full));
    end

    // Operand forwarding selects, independent of whether the operand is read.
    always_comb begin
        fwda = fwd_sel(id_rs, e_wreg, e_rn, m_wreg, m_rn, wb_done, wb_rn);
        fwdb = fwd_sel(id_rt, e_wreg, e_rn, m_wreg, m_rn, wb_done, wb_rn);
    end

    // Next-state for scoreboard, in-flight counter and sticky error flag.
    always_comb begin
        acc      = id_valid & nostall;
        long_acc = acc & id_wreg & id_long;
        set_en   = long_acc & (id_rd != '0);
        clr_en   = wb_done & (wb_rn != '0);

        pending_d = pending_q;
        if (clr_en) begin
            pending_d[wb_rn] = 1'b0;
        end
        if (set_en) begin
            pending_d[id_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        out_cnt_d = out_cnt_q;
        if (long_acc && !wb_done) begin
            if (out_cnt_q != MAXOUT_C) begin
                out_cnt_d = out_cnt_q + CW'(1);
            end
        end else if (!long_acc && wb_done && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - CW'(1);
        end

        sb_err_d = sb_err_q;
        if (wb_done) begin
            if ((out_cnt_q == '0) || ((wb_rn != '0) && !pending_q[wb_rn])) begin
                sb_err_d = 1'b1;
            end
        end
    end

    // State registers; reset drops all in-flight tracking at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            out_cnt_q <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            out_cnt_q <= out_cnt_d;
            sb_err_q  <= sb_err_d;
        end
    end

    assign pending = pending_q;
    assign out_cnt = out_cnt_q;
    assign sb_err  = sb_err_q;

`ifdef SB_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Stall-cycle counter: clear wins, otherwise saturating count of stalls.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (perf_clr) begin
            stall_cycles_d = '0;
        end else if (id_valid && !nostall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
